// File: rtl/plab3_mem_blocking_cache_nway.sv
// Blocking N-way set-associative write-back cache, each line tagged with a security domain.
// Ports: cachereq_*/cacheresp_* (CPU side), memreq_*/memresp_* (128-bit line memory side).
module plab3_mem_blocking_cache_nway #(
  parameter int p_num_ways     = 2,
  parameter int p_num_sets     = 8,
  parameter int p_opaque_nbits = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cachereq_val,
  output logic                      cachereq_rdy,
  input  logic                      cachereq_type,
  input  logic [p_opaque_nbits-1:0] cachereq_opaque,
  input  logic [31:0]               cachereq_addr,
  input  logic [31:0]               cachereq_data,
  input  logic                      cachereq_domain,
  output logic                      cacheresp_val,
  input  logic                      cacheresp_rdy,
  output logic                      cacheresp_type,
  output logic [p_opaque_nbits-1:0] cacheresp_opaque,
  output logic [31:0]               cacheresp_data,
  output logic                      memreq_val,
  input  logic                      memreq_rdy,
  output logic                      memreq_type,
  output logic [31:0]               memreq_addr,
  output logic [127:0]              memreq_data,
  output logic                      memreq_domain,
  input  logic                      memresp_val,
  output logic                      memresp_rdy,
  input  logic [127:0]              memresp_data
);
  localparam int IW = $clog2(p_num_sets);
  localparam int TW = 28 - IW;
  localparam int WW = (p_num_ways > 1) ? $clog2(p_num_ways) : 1;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] TAG_CHECK   = 3'd1;
  localparam logic [2:0] EVICT_REQ   = 3'd2;
  localparam logic [2:0] REFILL_REQ  = 3'd3;
  localparam logic [2:0] REFILL_WAIT = 3'd4;
  localparam logic [2:0] RESP        = 3'd5;

  logic [2:0]                state_q;
  logic                      type_q;
  logic                      dom_q;
  logic [p_opaque_nbits-1:0] opq_q;
  logic [TW-1:0]             tag_q;
  logic [IW-1:0]             idx_q;
  logic [1:0]                off_q;
  logic [31:0]               wdata_q;
  logic [31:0]               rword_q;
  logic [WW-1:0]             vic_q;

  logic [p_num_ways-1:0] val_q   [p_num_sets];
  logic [p_num_ways-1:0] dirty_q [p_num_sets];
  logic [p_num_ways-1:0] ldom_q  [p_num_sets];
  logic [WW-1:0]         rr_q    [p_num_sets];
  logic [TW-1:0]         ltag_q  [p_num_ways][p_num_sets];
  logic [127:0]          line_q  [p_num_ways][p_num_sets];

  logic          hit;
  logic [WW-1:0] hway;
  logic [WW-1:0] vic_d;
  logic [WW-1:0] rr_nxt;
  logic [127:0]  hline;
  logic [127:0]  vline;
  logic [127:0]  fill;
  logic          unused_addr;

  assign unused_addr = ^cachereq_addr[1:0];

  always_comb begin
    hit  = 1'b0;
    hway = '0;
    for (int w = 0; w < p_num_ways; w++) begin
      if (val_q[idx_q][w] && ldom_q[idx_q][w] == dom_q &&
          ltag_q[w][idx_q] == tag_q) begin
        hit  = 1'b1;
        hway = WW'(w);
      end
    end
    // Descending scan so the lowest invalid way is the last one kept.
    vic_d = rr_q[idx_q];
    for (int w = p_num_ways - 1; w >= 0; w--) begin
      if (!val_q[idx_q][w]) vic_d = WW'(w);
    end
    rr_nxt = (rr_q[idx_q] == WW'(p_num_ways - 1)) ? '0 : rr_q[idx_q] + 1'b1;
    hline  = line_q[hway][idx_q];
    vline  = line_q[vic_q][idx_q];
    fill   = memresp_data;
    if (type_q) fill[{off_q, 5'd0} +: 32] = wdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      type_q  <= 1'b0;
      dom_q   <= 1'b0;
      opq_q   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      vic_q   <= '0;
      for (int s = 0; s < p_num_sets; s++) begin
        val_q[s]   <= '0;
        dirty_q[s] <= '0;
        ldom_q[s]  <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cachereq_val) begin
            type_q  <= cachereq_type;
            opq_q   <= cachereq_opaque;
            tag_q   <= cachereq_addr[31 -: TW];
            idx_q   <= cachereq_addr[4 +: IW];
            off_q   <= cachereq_addr[3:2];
            wdata_q <= cachereq_data;
            dom_q   <= cachereq_domain;
            state_q <= TAG_CHECK;
          end
        end
        TAG_CHECK: begin
          if (hit) begin
            if (type_q) dirty_q[idx_q][hway] <= 1'b1;
            else rword_q <= hline[{off_q, 5'd0} +: 32];
            state_q <= RESP;
          end else begin
            vic_q   <= vic_d;
            state_q <= (val_q[idx_q][vic_d] && dirty_q[idx_q][vic_d])
                       ? EVICT_REQ : REFILL_REQ;
          end
        end
        EVICT_REQ: if (memreq_rdy) state_q <= REFILL_REQ;
        REFILL_REQ: if (memreq_rdy) state_q <= REFILL_WAIT;
        REFILL_WAIT: begin
          if (memresp_val) begin
            val_q[idx_q][vic_q]   <= 1'b1;
            dirty_q[idx_q][vic_q] <= type_q;
            ldom_q[idx_q][vic_q]  <= dom_q;
            rr_q[idx_q]           <= rr_nxt;
            if (!type_q) rword_q <= memresp_data[{off_q, 5'd0} +: 32];
            state_q <= RESP;
          end
        end
        RESP: if (cacheresp_rdy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (state_q == TAG_CHECK && hit && type_q)
      line_q[hway][idx_q][{off_q, 5'd0} +: 32] <= wdata_q;
    if (state_q == REFILL_WAIT && memresp_val) begin
      line_q[vic_q][idx_q] <= fill;
      ltag_q[vic_q][idx_q] <= tag_q;
    end
  end

  always_comb begin
    cachereq_rdy     = reset && (state_q == IDLE);
    cacheresp_val    = (state_q == RESP);
    cacheresp_type   = 1'b0;
    cacheresp_opaque = '0;
    cacheresp_data   = '0;
    if (cacheresp_val) begin
      cacheresp_type   = type_q;
      cacheresp_opaque = opq_q;
      cacheresp_data   = type_q ? 32'd0 : rword_q;
    end
    memreq_val    = 1'b0;
    memreq_type   = 1'b0;
    memreq_addr   = '0;
    memreq_data   = '0;
    memreq_domain = 1'b0;
    if (state_q == EVICT_REQ) begin
      memreq_val    = 1'b1;
      memreq_type   = 1'b1;
      memreq_addr   = {ltag_q[vic_q][idx_q], idx_q, 4'b0};
      memreq_data   = vline;
      memreq_domain = ldom_q[idx_q][vic_q];
    end
    if (state_q == REFILL_REQ) begin
      memreq_val    = 1'b1;
      memreq_addr   = {tag_q, idx_q, 4'b0};
      memreq_domain = dom_q;
    end
    memresp_rdy = (state_q == REFILL_WAIT);
  end
endmodule

// File: tb/tb_plab3_mem_blocking_cache_nway.sv
// Testbench for plab3_mem_blocking_cache_nway: directed scenarios plus randomized traffic
// against an array-based cache/memory reference model, with a reactive memory responder.
module tb_plab3_mem_blocking_cache_nway;
  localparam int W  = 2;
  localparam int S  = 8;
  localparam int O  = 8;
  localparam int TW = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic          cachereq_val, cachereq_rdy, cachereq_type, cachereq_domain;
  logic [O-1:0]  cachereq_opaque;
  logic [31:0]   cachereq_addr, cachereq_data;
  logic          cacheresp_val, cacheresp_rdy, cacheresp_type;
  logic [O-1:0]  cacheresp_opaque;
  logic [31:0]   cacheresp_data;
  logic          memreq_val, memreq_rdy, memreq_type, memreq_domain;
  logic [31:0]   memreq_addr;
  logic [127:0]  memreq_data;
  logic          memresp_val, memresp_rdy;
  logic [127:0]  memresp_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  plab3_mem_blocking_cache_nway #(
    .p_num_ways(W), .p_num_sets(S), .p_opaque_nbits(O)
  ) dut (
    .clk(clk), .reset(reset),
    .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy),
    .cachereq_type(cachereq_type), .cachereq_opaque(cachereq_opaque),
    .cachereq_addr(cachereq_addr), .cachereq_data(cachereq_data),
    .cachereq_domain(cachereq_domain),
    .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy),
    .cacheresp_type(cacheresp_type), .cacheresp_opaque(cacheresp_opaque),
    .cacheresp_data(cacheresp_data),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memreq_type(memreq_type), .memreq_addr(memreq_addr),
    .memreq_data(memreq_data), .memreq_domain(memreq_domain),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .memresp_data(memresp_data)
  );

  typedef struct {
    logic         t;
    logic [31:0]  a;
    logic [127:0] d;
    logic         dom;
  } mreq_t;

  typedef struct {
    bit           v;
    bit           d;
    bit           dom;
    logic [TW-1:0] tag;
    logic [127:0] line;
  } ent_t;

  ent_t         mc [S][W];
  int           rr [S];
  logic [127:0] mm [logic [31:0]];
  logic [127:0] em [logic [31:0]];
  mreq_t        exp_q[$];
  mreq_t        obs_q[$];
  logic [31:0]  m_data;
  bit           m_hit;

  logic [31:0]  r_data;
  logic         r_type;
  logic [O-1:0] r_op;
  int           r_lat;
  bit           r_tmo;
  bit           r_unst;

  function automatic logic [127:0] init_line(input logic [31:0] la);
    return {la ^ 32'h0F0F0003, la ^ 32'h33330002, la ^ 32'h55550001, la ^ 32'hAAAA0000};
  endfunction

  function automatic logic [127:0] mm_get(input logic [31:0] la);
    if (mm.exists(la)) return mm[la];
    return init_line(la);
  endfunction

  function automatic logic [127:0] em_get(input logic [31:0] la);
    if (em.exists(la)) return em[la];
    return init_line(la);
  endfunction

  function automatic void set_line(input logic [31:0] la, input logic [127:0] l);
    mm[la] = l;
    em[la] = l;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < S; s++) begin
      rr[s] = 0;
      for (int w = 0; w < W; w++) begin
        mc[s][w].v = 1'b0;
        mc[s][w].d = 1'b0;
        mc[s][w].dom = 1'b0;
      end
    end
  endfunction

  // Predicts response data, hit, and the ordered list of memory requests.
  function automatic void model_access(input bit t, input logic [31:0] a,
                                       input logic [31:0] d, input bit dom);
    int s;
    int v;
    int off;
    logic [TW-1:0] tg;
    logic [31:0] la;
    s = int'(a[6:4]);
    off = int'(a[3:2]);
    tg = a[31:7];
    exp_q.delete();
    m_hit = 1'b0;
    v = -1;
    for (int w = 0; w < W; w++)
      if (mc[s][w].v && mc[s][w].tag == tg && mc[s][w].dom == dom) begin
        m_hit = 1'b1;
        v = w;
      end
    if (!m_hit) begin
      for (int w = W - 1; w >= 0; w--)
        if (!mc[s][w].v) v = w;
      if (v < 0) v = rr[s];
      if (mc[s][v].v && mc[s][v].d) begin
        la = {mc[s][v].tag, a[6:4], 4'b0};
        exp_q.push_back('{1'b1, la, mc[s][v].line, mc[s][v].dom});
        mm[la] = mc[s][v].line;
      end
      la = {tg, a[6:4], 4'b0};
      exp_q.push_back('{1'b0, la, 128'd0, dom});
      mc[s][v].v = 1'b1;
      mc[s][v].d = 1'b0;
      mc[s][v].dom = dom;
      mc[s][v].tag = tg;
      mc[s][v].line = mm_get(la);
      rr[s] = (rr[s] + 1) % W;
    end
    if (t) begin
      mc[s][v].line[off*32 +: 32] = d;
      mc[s][v].d = 1'b1;
      m_data = 32'd0;
    end else begin
      m_data = mc[s][v].line[off*32 +: 32];
    end
  endfunction

  function automatic bit q_match();
    if (exp_q.size() != obs_q.size()) return 1'b0;
    foreach (exp_q[i])
      if (exp_q[i].t !== obs_q[i].t || exp_q[i].a !== obs_q[i].a ||
          exp_q[i].d !== obs_q[i].d || exp_q[i].dom !== obs_q[i].dom)
        return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [206:0] outs();
    return {cachereq_rdy, cacheresp_val, cacheresp_type, cacheresp_opaque,
            cacheresp_data, memreq_val, memreq_type, memreq_addr, memreq_data,
            memreq_domain, memresp_rdy};
  endfunction

  task automatic idle_inputs();
    cachereq_val = 1'b0;
    cachereq_type = 1'b0;
    cachereq_opaque = '0;
    cachereq_addr = '0;
    cachereq_data = '0;
    cachereq_domain = 1'b0;
    cacheresp_rdy = 1'b0;
    memreq_rdy = 1'b0;
    memresp_val = 1'b0;
    memresp_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Drives one request and acts as the memory; records observations only.
  task automatic run_txn(input bit t, input logic [31:0] a, input logic [31:0] d,
                         input bit dom, input logic [O-1:0] op,
                         input int rstall, input int mstall);
    int cyc = 0;
    int acc = -1;
    int first = -1;
    int pdel = 0;
    int rs = rstall;
    int ms = mstall;
    bit acc_d = 1'b0;
    bit done = 1'b0;
    bit pend = 1'b0;
    bit pv_m = 1'b0;
    bit pv_r = 1'b0;
    logic [31:0] pa = '0;
    mreq_t lm;
    logic [31:0] lrd = '0;
    logic [O-1:0] lop = '0;
    logic lty = 1'b0;
    obs_q.delete();
    r_unst = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cachereq_val = !acc_d;
      cachereq_type = t;
      cachereq_addr = a;
      cachereq_data = d;
      cachereq_domain = dom;
      cachereq_opaque = op;
      if (cachereq_val && cachereq_rdy) begin
        acc_d = 1'b1;
        acc = cyc;
      end
      if (pv_m && !memreq_val) r_unst = 1'b1;
      if (memreq_val) begin
        if (pv_m && (memreq_type !== lm.t || memreq_addr !== lm.a ||
                     memreq_data !== lm.d || memreq_domain !== lm.dom))
          r_unst = 1'b1;
        if (ms > 0) begin
          memreq_rdy = 1'b0;
          ms--;
        end else begin
          memreq_rdy = ($urandom_range(0, 3) != 0);
        end
        if (memreq_rdy) begin
          obs_q.push_back('{memreq_type, memreq_addr, memreq_data, memreq_domain});
          if (memreq_type) em[memreq_addr] = memreq_data;
          else begin
            pend = 1'b1;
            pa = memreq_addr;
            pdel = $urandom_range(0, 2);
          end
          pv_m = 1'b0;
        end else begin
          pv_m = 1'b1;
          lm = '{memreq_type, memreq_addr, memreq_data, memreq_domain};
        end
      end else begin
        memreq_rdy = $urandom_range(0, 1);
      end
      memresp_val = 1'b0;
      if (memresp_rdy) begin
        if (pend && pdel == 0) begin
          memresp_val = 1'b1;
          memresp_data = em_get(pa);
          pend = 1'b0;
        end else if (pend) begin
          pdel--;
        end
      end else begin
        memresp_val = $urandom_range(0, 1);
        memresp_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (cacheresp_val) begin
        if (first < 0) first = cyc;
        if (pv_r && (cacheresp_data !== lrd || cacheresp_opaque !== lop ||
                     cacheresp_type !== lty))
          r_unst = 1'b1;
        if (rs > 0) begin
          cacheresp_rdy = 1'b0;
          rs--;
        end else begin
          cacheresp_rdy = ($urandom_range(0, 3) != 0);
        end
        if (cacheresp_rdy) begin
          r_data = cacheresp_data;
          r_type = cacheresp_type;
          r_op = cacheresp_opaque;
          done = 1'b1;
        end else begin
          pv_r = 1'b1;
          lrd = cacheresp_data;
          lop = cacheresp_opaque;
          lty = cacheresp_type;
        end
      end else begin
        if (pv_r) r_unst = 1'b1;
        cacheresp_rdy = $urandom_range(0, 1);
      end
      @(posedge clk);
      cyc++;
    end
    r_tmo = !done;
    r_lat = (acc >= 0 && first >= 0) ? first - acc : -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %h want 0", outs());
    end
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (cachereq_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_rdy got %b want 1", cachereq_rdy);
    end
  endtask

  task automatic test_cold_read();
    set_line(32'h1000, {32'h0000_3333, 32'h0000_2222, 32'hDEADBEEF, 32'h0000_0000});
    model_access(1'b0, 32'h1004, 32'd0, 1'b0);
    run_txn(1'b0, 32'h1004, 32'd0, 1'b0, 8'h11, 0, 0);
    checks++;
    if (r_tmo || obs_q.size() != 1 || obs_q[0].a !== 32'h1000 || obs_q[0].t !== 1'b0) begin
      failures++;
      $display("FAIL cold_memreq got n=%0d addr=%h want n=1 addr=00001000 read",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].a : 32'h0);
    end
    checks++;
    if (r_data !== 32'hDEADBEEF || r_op !== 8'h11) begin
      failures++;
      $display("FAIL cold_data got %h op %h want deadbeef op 11", r_data, r_op);
    end
    model_access(1'b0, 32'h1004, 32'd0, 1'b0);
    run_txn(1'b0, 32'h1004, 32'd0, 1'b0, 8'h12, 0, 0);
    checks++;
    if (obs_q.size() != 0 || r_lat != 2 || r_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL reread_hit got n=%0d lat=%0d data=%h want n=0 lat=2 data=deadbeef",
               obs_q.size(), r_lat, r_data);
    end
  endtask

  task automatic test_write_hit();
    model_access(1'b1, 32'h1008, 32'h12345678, 1'b0);
    run_txn(1'b1, 32'h1008, 32'h12345678, 1'b0, 8'h21, 0, 0);
    checks++;
    if (obs_q.size() != 0 || r_type !== 1'b1 || r_data !== 32'd0 || r_lat != 2) begin
      failures++;
      $display("FAIL write_hit got n=%0d type=%b data=%h lat=%0d want n=0 type=1 data=0 lat=2",
               obs_q.size(), r_type, r_data, r_lat);
    end
    model_access(1'b0, 32'h1008, 32'd0, 1'b0);
    run_txn(1'b0, 32'h1008, 32'd0, 1'b0, 8'h22, 0, 0);
    checks++;
    if (r_data !== 32'h12345678 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL write_readback got %h n=%0d want 12345678 n=0", r_data, obs_q.size());
    end
  endtask

  task automatic test_writeback();
    do_reset();
    model_access(1'b1, 32'h1000, 32'hCAFEF00D, 1'b0);
    run_txn(1'b1, 32'h1000, 32'hCAFEF00D, 1'b0, 8'h31, 0, 0);
    model_access(1'b0, 32'h1080, 32'd0, 1'b0);
    run_txn(1'b0, 32'h1080, 32'd0, 1'b0, 8'h32, 0, 0);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].t !== 1'b0) begin
      failures++;
      $display("FAIL wb_fill_second got n=%0d want 1 refill", obs_q.size());
    end
    model_access(1'b0, 32'h1100, 32'd0, 1'b0);
    run_txn(1'b0, 32'h1100, 32'd0, 1'b0, 8'h33, 0, 0);
    checks++;
    if (obs_q.size() != 2 || obs_q[0].t !== 1'b1 || obs_q[0].a !== 32'h1000 ||
        obs_q[0].d[31:0] !== 32'hCAFEF00D || obs_q[1].t !== 1'b0 ||
        obs_q[1].a !== 32'h1100) begin
      failures++;
      $display("FAIL wb_order got n=%0d first=%h/%b want 2 reqs: write 00001000 then read 00001100",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].a : 32'h0,
               obs_q.size() > 0 ? obs_q[0].t : 1'b0);
    end
    checks++;
    if (!q_match()) begin
      failures++;
      $display("FAIL wb_model got n=%0d want n=%0d", obs_q.size(), exp_q.size());
    end
    model_access(1'b0, 32'h1000, 32'd0, 1'b0);
    run_txn(1'b0, 32'h1000, 32'd0, 1'b0, 8'h34, 0, 0);
    checks++;
    if (r_data !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL wb_refetch got %h want cafef00d", r_data);
    end
  endtask

  task automatic test_domain();
    do_reset();
    model_access(1'b0, 32'h2000, 32'd0, 1'b0);
    run_txn(1'b0, 32'h2000, 32'd0, 1'b0, 8'h41, 0, 0);
    model_access(1'b0, 32'h2000, 32'd0, 1'b1);
    run_txn(1'b0, 32'h2000, 32'd0, 1'b1, 8'h42, 0, 0);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].dom !== 1'b1 || obs_q[0].a !== 32'h2000) begin
      failures++;
      $display("FAIL domain_miss got n=%0d dom=%b want n=1 dom=1 addr=00002000",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0].dom : 1'b0);
    end
    model_access(1'b1, 32'h2000, 32'hBBBB0001, 1'b1);
    run_txn(1'b1, 32'h2000, 32'hBBBB0001, 1'b1, 8'h43, 0, 0);
    model_access(1'b0, 32'h2000, 32'd0, 1'b0);
    run_txn(1'b0, 32'h2000, 32'd0, 1'b0, 8'h44, 0, 0);
    checks++;
    if (r_data === 32'hBBBB0001 || r_data !== m_data || obs_q.size() != 0) begin
      failures++;
      $display("FAIL domain_isolation got %h n=%0d want %h n=0", r_data, obs_q.size(), m_data);
    end
  endtask

  task automatic test_stall();
    model_access(1'b0, 32'h5024, 32'd0, 1'b0);
    run_txn(1'b0, 32'h5024, 32'd0, 1'b0, 8'h51, 5, 3);
    checks++;
    if (r_tmo || r_unst || !q_match() || r_data !== m_data || r_op !== 8'h51) begin
      failures++;
      $display("FAIL stall_read got tmo=%b unst=%b n=%0d data=%h want 0 0 n=%0d data=%h",
               r_tmo, r_unst, obs_q.size(), r_data, exp_q.size(), m_data);
    end
    model_access(1'b1, 32'h5028, 32'h0BADCAFE, 1'b0);
    run_txn(1'b1, 32'h5028, 32'h0BADCAFE, 1'b0, 8'h52, 5, 3);
    checks++;
    if (r_tmo || r_unst || obs_q.size() != 0 || r_data !== 32'd0 || r_type !== 1'b1) begin
      failures++;
      $display("FAIL stall_write got tmo=%b unst=%b n=%0d data=%h want 0 0 0 0",
               r_tmo, r_unst, obs_q.size(), r_data);
    end
  endtask

  task automatic test_reset_mid_miss();
    int n = 0;
    @(negedge clk);
    idle_inputs();
    cachereq_val = 1'b1;
    cachereq_addr = 32'h3000;
    cachereq_opaque = 8'h61;
    memreq_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cachereq_val = 1'b0;
    while (!memresp_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (memresp_rdy !== 1'b1) begin
      failures++;
      $display("FAIL midmiss_wait got memresp_rdy=%b want 1", memresp_rdy);
    end
    reset = 1'b0;
    memresp_val = 1'b1;
    memresp_data = {4{32'h77777777}};
    #1;
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL midmiss_outputs got %h want 0", outs());
    end
    @(negedge clk);
    @(negedge clk);
    memresp_val = 1'b0;
    memreq_rdy = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (cachereq_rdy !== 1'b1) begin
      failures++;
      $display("FAIL midmiss_release_rdy got %b want 1", cachereq_rdy);
    end
    model_access(1'b0, 32'h3000, 32'd0, 1'b0);
    run_txn(1'b0, 32'h3000, 32'd0, 1'b0, 8'h62, 0, 0);
    checks++;
    if (obs_q.size() != 1 || !q_match() || r_data !== m_data) begin
      failures++;
      $display("FAIL midmiss_remiss got n=%0d data=%h want n=1 data=%h",
               obs_q.size(), r_data, m_data);
    end
  endtask

  task automatic test_random();
    bit t;
    bit dom;
    logic [31:0] a;
    logic [31:0] d;
    logic [O-1:0] op;
    for (int i = 0; i < 200; i++) begin
      t = $urandom_range(0, 1);
      dom = $urandom_range(0, 1);
      a = 32'h4000 | ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 4) |
          ($urandom_range(0, 3) << 2);
      d = $urandom;
      op = O'($urandom_range(0, 255));
      model_access(t, a, d, dom);
      run_txn(t, a, d, dom, op, $urandom_range(0, 2), $urandom_range(0, 2));
      checks++;
      if (r_tmo || r_unst) begin
        failures++;
        $display("FAIL rand_handshake txn %0d got tmo=%b unst=%b want 0 0", i, r_tmo, r_unst);
        if (r_tmo) break;
      end
      checks++;
      if (r_data !== m_data || r_type !== t || r_op !== op) begin
        failures++;
        $display("FAIL rand_resp txn %0d addr %h got %h/%b/%h want %h/%b/%h",
                 i, a, r_data, r_type, r_op, m_data, t, op);
      end
      checks++;
      if (!q_match()) begin
        failures++;
        $display("FAIL rand_memreq txn %0d got n=%0d first=%h want n=%0d first=%h",
                 i, obs_q.size(), obs_q.size() > 0 ? obs_q[0].a : 32'h0,
                 exp_q.size(), exp_q.size() > 0 ? exp_q[0].a : 32'h0);
      end
      if (m_hit) begin
        checks++;
        if (r_lat != 2) begin
          failures++;
          $display("FAIL rand_hit_latency txn %0d got %0d want 2", i, r_lat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_writeback();
    test_domain();
    test_stall();
    test_reset_mid_miss();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
